// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word-addressed memory, LATENCY-stage read pipeline, response queue.
// Define IMEM_STATS_EN to add the fetch_count/stall_count statistics ports.
module instr_mem_responder #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instr,
    output logic [31:0] resp_addr,
    output logic        resp_misaligned,
`ifdef IMEM_STATS_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        mis;
    } entry_t;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    entry_t        fetch_entry;
    entry_t        push_entry;
    logic [CW-1:0] in_flight;

    entry_t        q_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    entry_t        head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    // Upper address bits alias; only the word index selects a location.
    logic unused_load_bits;
    assign unused_load_bits = ^{load_addr[31:AW+2], load_addr[1:0]};

    // Pipeline and queue occupancy are both counted so no accepted fetch can be dropped.
    assign req_ready = !flush && ((32'(in_flight) + 32'(count_q)) < FIFO_DEPTH);
    assign accept    = req_valid && req_ready;

    always_comb begin
        fetch_entry.addr  = req_addr;
        fetch_entry.mis   = (req_addr[1:0] != 2'b00);
        fetch_entry.instr = fetch_entry.mis ? NOP : mem[req_addr[AW+1:2]];
    end

    if (LATENCY == 1) begin : g_direct
        assign push       = accept;
        assign push_entry = fetch_entry;
        assign in_flight  = '0;
    end else begin : g_pipe
        logic [LATENCY-2:0] vld_q;
        entry_t             data_q [LATENCY-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
            end else if (flush) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            data_q[0] <= fetch_entry;
            for (int i = 1; i < LATENCY - 1; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end

        always_comb begin
            in_flight = '0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                in_flight = in_flight + CW'(vld_q[i]);
            end
        end

        assign push       = vld_q[LATENCY-2];
        assign push_entry = data_q[LATENCY-2];
    end

    assign head       = q_mem[rd_ptr_q];
    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid && resp_ready;

    // Head fields are forced to zero while empty so reset/flush present a clean bus.
    assign resp_instr      = resp_valid ? head.instr : '0;
    assign resp_addr       = resp_valid ? head.addr  : '0;
    assign resp_misaligned = resp_valid && head.mis;

    always_comb begin
        count_d = count_q;
        if (push) count_d = count_d + CW'(1);
        if (pop)  count_d = count_d - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            q_mem[wr_ptr_q] <= push_entry;
        end
    end

`ifdef IMEM_STATS_EN
    logic [31:0] fetch_count_q, stall_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (accept)                  fetch_count_q <= fetch_count_q + 32'd1;
            if (req_valid && !req_ready) stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (LATENCY=1/FIFO_DEPTH=2, LATENCY=3/FIFO_DEPTH=4)
// share stimulus; a queue-based reference model is compared against both every cycle.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b1;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic        o_ready [2];
    logic        o_valid [2];
    logic [31:0] o_instr [2];
    logic [31:0] o_addr  [2];
    logic        o_mis   [2];
`ifdef IMEM_STATS_EN
    logic [31:0] fc [2];
    logic [31:0] sc [2];
`endif

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH(256), .LATENCY(1), .FIFO_DEPTH(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(o_ready[0]),
        .flush(flush),
        .resp_valid(o_valid[0]), .resp_ready(resp_ready), .resp_instr(o_instr[0]),
        .resp_addr(o_addr[0]), .resp_misaligned(o_mis[0]),
`ifdef IMEM_STATS_EN
        .fetch_count(fc[0]), .stall_count(sc[0]),
`endif
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    instr_mem_responder #(.DEPTH(256), .LATENCY(3), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(o_ready[1]),
        .flush(flush),
        .resp_valid(o_valid[1]), .resp_ready(resp_ready), .resp_instr(o_instr[1]),
        .resp_addr(o_addr[1]), .resp_misaligned(o_mis[1]),
`ifdef IMEM_STATS_EN
        .fetch_count(fc[1]), .stall_count(sc[1]),
`endif
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    // Reference model: every accepted fetch is an entry that becomes visible at cycle rdy.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        mis;
        int unsigned rdy;
    } ent_t;

    ent_t        mb [2][64];
    int          mh [2] = '{0, 0};
    int          mt [2] = '{0, 0};
    logic [31:0] mm [256];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int fdep(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic bit exp_valid(input int k);
        return (mt[k] - mh[k]) > 0 && mb[k][mh[k] % 64].rdy <= cyc;
    endfunction

    function automatic bit exp_ready(input int k);
        return !flush && ((mt[k] - mh[k]) < fdep(k));
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d @%0t: got %h want %h", name, k, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset || flush) begin
                mh[k] <= mt[k];
            end else begin
                if (exp_valid(k) && resp_ready) mh[k] <= mh[k] + 1;
                if (req_valid && exp_ready(k)) begin
                    mb[k][mt[k] % 64] <= '{
                        instr: (req_addr[1:0] != 2'b00) ? 32'h0000_0013 : mm[req_addr[9:2]],
                        addr:  req_addr,
                        mis:   (req_addr[1:0] != 2'b00),
                        rdy:   cyc + lat(k)};
                    mt[k] <= mt[k] + 1;
                end
            end
        end
        if (load_we) mm[load_addr[9:2]] <= load_data;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                chk("resp_valid", k, 32'(o_valid[k]), 32'(exp_valid(k)));
                chk("req_ready", k, 32'(o_ready[k]), 32'(exp_ready(k)));
                if (exp_valid(k)) begin
                    chk("resp_instr", k, o_instr[k], mb[k][mh[k] % 64].instr);
                    chk("resp_addr", k, o_addr[k], mb[k][mh[k] % 64].addr);
                    chk("resp_misaligned", k, 32'(o_mis[k]), 32'(mb[k][mh[k] % 64].mis));
                end
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (n) nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        repeat (3) nxt();
        reset = 1'b0;
        nxt();
        chk("reset resp_valid", 0, 32'(o_valid[0]), 32'd0);
        chk("reset resp_instr", 0, o_instr[0], 32'h0);
        chk("reset resp_addr", 0, o_addr[0], 32'h0);
        chk("reset resp_misaligned", 0, 32'(o_mis[0]), 32'd0);
        chk("reset req_ready", 0, 32'(o_ready[0]), 32'd1);

        // Program load: word i = 0x10000000 + i*0x10101, word 1 = addi x1,x0,5.
        for (int i = 0; i < 32; i++) begin
            load_we   = 1'b1;
            load_addr = 32'(i * 4);
            load_data = (i == 1) ? 32'h0050_0093 : 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            nxt();
        end
        load_we = 1'b0;

        // Single fetch, LATENCY=1 response in the next cycle.
        req_valid = 1'b1; req_addr = 32'h4;
        nxt();
        req_valid = 1'b0;
        chk("lat1 valid", 0, 32'(o_valid[0]), 32'd1);
        chk("lat1 instr", 0, o_instr[0], 32'h0050_0093);
        chk("lat1 addr", 0, o_addr[0], 32'h4);
        chk("lat1 mis", 0, 32'(o_mis[0]), 32'd0);
        drain(8);

        // Backpressure fills the queue, then drains in order.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        nxt();
        req_addr = 32'h4;
        nxt();
        req_addr = 32'h8;
        chk("full ready", 0, 32'(o_ready[0]), 32'd0);
        nxt();
        resp_ready = 1'b1;
        chk("full ready held", 0, 32'(o_ready[0]), 32'd0);
        chk("order head0", 0, o_addr[0], 32'h0);
        nxt();
        chk("credit return", 0, 32'(o_ready[0]), 32'd1);
        chk("order head1", 0, o_addr[0], 32'h4);
        nxt();
        req_valid = 1'b0;
        chk("order head2", 0, o_addr[0], 32'h8);
        drain(10);

        // Flush with two fetches outstanding and a competing request.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8;
        nxt();
        req_addr = 32'hC;
        nxt();
        flush = 1'b1; req_addr = 32'h20;
        #1;
        chk("flush ready", 0, 32'(o_ready[0]), 32'd0);
        nxt();
        chk("post flush valid0", 0, 32'(o_valid[0]), 32'd0);
        chk("post flush valid1", 1, 32'(o_valid[1]), 32'd0);
        flush = 1'b0; req_addr = 32'h40; resp_ready = 1'b1;
        nxt();
        req_valid = 1'b0;
        chk("after flush valid", 0, 32'(o_valid[0]), 32'd1);
        chk("after flush addr", 0, o_addr[0], 32'h40);
        chk("after flush instr", 0, o_instr[0], 32'h1010_1010);
        drain(8);

        // Misaligned fetch returns a NOP without reading memory.
        req_valid = 1'b1; req_addr = 32'h6;
        nxt();
        req_valid = 1'b0;
        chk("mis instr", 0, o_instr[0], 32'h0000_0013);
        chk("mis flag", 0, 32'(o_mis[0]), 32'd1);
        chk("mis addr", 0, o_addr[0], 32'h6);
        drain(8);

        // Aliasing and load/fetch collision.
        load_we = 1'b1; load_addr = 32'h4; load_data = 32'hDEAD_BEEF;
        nxt();
        load_we = 1'b0;
        req_valid = 1'b1; req_addr = 32'h404;
        nxt();
        chk("alias instr", 0, o_instr[0], 32'hDEAD_BEEF);
        chk("alias addr", 0, o_addr[0], 32'h404);
        req_addr = 32'h4;
        load_we = 1'b1; load_addr = 32'h4; load_data = 32'h1234_5678;
        nxt();
        load_we = 1'b0;
        chk("collide old", 0, o_instr[0], 32'hDEAD_BEEF);
        nxt();
        req_valid = 1'b0;
        chk("collide new", 0, o_instr[0], 32'h1234_5678);
        drain(8);

        // Reset with three fetches outstanding on the LATENCY=3 instance.
        req_valid = 1'b1; req_addr = 32'h0;
        nxt();
        req_addr = 32'h4;
        nxt();
        req_addr = 32'h8;
        nxt();
        chk("lat3 first visible", 1, 32'(o_valid[1]), 32'd1);
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("reset async valid1", 1, 32'(o_valid[1]), 32'd0);
        chk("reset async valid0", 0, 32'(o_valid[0]), 32'd0);
        nxt();
        nxt();
        reset = 1'b0;
        nxt();
        chk("post reset ready", 1, 32'(o_ready[1]), 32'd1);
        chk("post reset valid", 1, 32'(o_valid[1]), 32'd0);
`ifdef IMEM_STATS_EN
        chk("fetch_count reset", 0, fc[0], 32'd0);
        chk("fetch_count reset", 1, fc[1], 32'd0);
`endif
        drain(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
